// File: rtl/cov_sum_accumulator.sv
// Coverage sum accumulator: counts distinct hashed coverage indices since the
// last clear, using a DEPTH x 1 seen-bitmap with a synchronous read port.
// A sweep FSM zeroes the bitmap after reset and whenever a new round starts.
//
// Handshake: cov_valid has no ready. An index is accepted on every RUN cycle
// it is valid and silently dropped while clear_busy is high or on the cycle
// clear_req is pulsed. new_hit is a one-cycle pulse, two edges after cov_valid.
module cov_sum_accumulator #(
    parameter int IDX_W = 10,
    parameter int SUM_W = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cov_valid,
    input  logic [IDX_W-1:0] cov_idx,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic             new_hit,
    output logic [SUM_W-1:0] cov_sum,
    output logic             dbg_state
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_PTR = '1;
    localparam logic [SUM_W-1:0] SUM_MAX  = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sweep_ptr_q, sweep_ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [IDX_W-1:0] fwd_idx_q, fwd_idx_d;
    logic             new_hit_q, new_hit_d;
    logic [SUM_W-1:0] cov_sum_q, cov_sum_d;
    logic             clear_busy_q, clear_busy_d;

    // Bitmap storage: no reset, contents are defined only by the sweep.
    logic             bitmap [DEPTH];
    logic             rd_bit_q;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic             wr_data;
    logic [IDX_W-1:0] rd_addr;
    logic             seen;
    logic             hit;

    // Next-state, pipeline and single-write-port arbitration.
    always_comb begin
        state_d      = state_q;
        sweep_ptr_d  = sweep_ptr_q;
        s1_valid_d   = 1'b0;
        s1_idx_d     = s1_idx_q;
        fwd_valid_d  = 1'b0;
        fwd_idx_d    = fwd_idx_q;
        new_hit_d    = 1'b0;
        cov_sum_d    = cov_sum_q;
        wr_en        = 1'b0;
        wr_addr      = sweep_ptr_q;
        wr_data      = 1'b0;
        // Masking the address keeps an undriven cov_idx out of the read path.
        rd_addr      = cov_valid ? cov_idx : '0;
        // The previous hit's write lands on the same edge as this entry's read,
        // so the read data is stale for a back-to-back duplicate.
        seen         = rd_bit_q || (fwd_valid_q && (fwd_idx_q == s1_idx_q));
        hit          = (state_q == ST_RUN) && !clear_req && s1_valid_q && !seen;

        case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = sweep_ptr_q;
                wr_data   = 1'b0;
                cov_sum_d = '0;
                if (clear_req) begin
                    sweep_ptr_d = '0;
                end else if (sweep_ptr_q == LAST_PTR) begin
                    state_d     = ST_RUN;
                    sweep_ptr_d = '0;
                end else begin
                    sweep_ptr_d = sweep_ptr_q + 1'b1;
                end
            end
            default: begin
                if (clear_req) begin
                    // Anything in S1/S2 is squashed by leaving s1_valid_d low.
                    state_d     = ST_CLEAR;
                    sweep_ptr_d = '0;
                    cov_sum_d   = '0;
                end else begin
                    s1_valid_d = cov_valid;
                    if (cov_valid) begin
                        s1_idx_d = cov_idx;
                    end
                    if (hit) begin
                        wr_en       = 1'b1;
                        wr_addr     = s1_idx_q;
                        wr_data     = 1'b1;
                        new_hit_d   = 1'b1;
                        fwd_valid_d = 1'b1;
                        fwd_idx_d   = s1_idx_q;
                        if (cov_sum_q != SUM_MAX) begin
                            cov_sum_d = cov_sum_q + 1'b1;
                        end
                    end
                end
            end
        endcase

        clear_busy_d = (state_d == ST_CLEAR);
    end

    // Control, pipeline and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            sweep_ptr_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_idx_q    <= '0;
            new_hit_q    <= 1'b0;
            cov_sum_q    <= '0;
            clear_busy_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sweep_ptr_q  <= sweep_ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_idx_q     <= s1_idx_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_idx_q    <= fwd_idx_d;
            new_hit_q    <= new_hit_d;
            cov_sum_q    <= cov_sum_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    // Seen-bitmap: one write port, registered read (read-before-write).
    always_ff @(posedge clock) begin
        if (wr_en) begin
            bitmap[wr_addr] <= wr_data;
        end
        rd_bit_q <= bitmap[rd_addr];
    end

    assign clear_busy = clear_busy_q;
    assign new_hit    = new_hit_q;
    assign cov_sum    = cov_sum_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cov_sum_accumulator.sv
// Bench for cov_sum_accumulator: directed vectors, expected cov_sum values are
// pushed at issue time and popped by a monitor on every new_hit pulse.
module tb_cov_sum_accumulator;

  logic        clock;
  logic        reset;
  logic        cov_valid;
  logic [9:0]  cov_idx;
  logic        clear_req;
  logic        clear_busy;
  logic        new_hit;
  logic [29:0] cov_sum;
  logic        dbg_state;

  logic        sat_valid;
  logic [9:0]  sat_idx;
  logic        sat_clear_req;
  logic        sat_clear_busy;
  logic        sat_new_hit;
  logic [1:0]  sat_sum;
  logic        sat_dbg_state;

  int checks = 0;
  int failures = 0;
  int sat_hits = 0;
  logic [29:0] exp_q[$];

  cov_sum_accumulator #(.IDX_W(10), .SUM_W(30)) dut (
    .clock(clock), .reset(reset), .cov_valid(cov_valid), .cov_idx(cov_idx),
    .clear_req(clear_req), .clear_busy(clear_busy), .new_hit(new_hit),
    .cov_sum(cov_sum), .dbg_state(dbg_state)
  );

  cov_sum_accumulator #(.IDX_W(10), .SUM_W(2)) dut_sat (
    .clock(clock), .reset(reset), .cov_valid(sat_valid), .cov_idx(sat_idx),
    .clear_req(sat_clear_req), .clear_busy(sat_clear_busy), .new_hit(sat_new_hit),
    .cov_sum(sat_sum), .dbg_state(sat_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete within time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // scoreboard monitor: every new_hit must match the next expected cov_sum
  always @(negedge clock) begin
    if (!reset && new_hit) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_new_hit: got cov_sum %0d expected no pulse", cov_sum);
      end else begin
        logic [29:0] e;
        e = exp_q.pop_front();
        if (cov_sum !== e) begin
          failures++;
          $display("FAIL hit_sum: got %0d expected %0d", cov_sum, e);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && sat_new_hit) sat_hits++;
  end

  // driver tasks
  task automatic send(input logic [9:0] idx, input bit exp_new, input logic [29:0] exp_sum);
    cov_valid = 1'b1;
    cov_idx   = idx;
    if (exp_new) exp_q.push_back(exp_sum);
    @(posedge clock); #1;
    cov_valid = 1'b0;
    cov_idx   = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // count cycles until clear_busy drops; optionally poke cov_valid meanwhile
  task automatic wait_sweep(input bit poke, output int n);
    n = 0;
    while (clear_busy && n < 2000) begin
      cov_valid = poke && (n % 7 == 3);
      cov_idx   = 10'($urandom_range(0, 1023));
      @(posedge clock); #1;
      n++;
    end
    cov_valid = 1'b0;
    cov_idx   = 'x;
  endtask

  initial begin
    int n;
    reset = 1'b1; cov_valid = 1'b0; cov_idx = '0; clear_req = 1'b0;
    sat_valid = 1'b0; sat_idx = '0; sat_clear_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(clear_busy), 1);
    check("rst_sum", 32'(cov_sum), 0);
    check("rst_new_hit", 32'(new_hit), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b0;

    // initial sweep, with inputs that must be dropped
    wait_sweep(1'b1, n);
    check("sweep1_len", n, 1024);
    check("sweep1_sum", 32'(cov_sum), 0);
    check("run_state", 32'(dbg_state), 1);

    // distinct and repeated indices
    send(10'd5, 1, 30'd1);
    send(10'd9, 1, 30'd2);
    send(10'd5, 0, 30'd0);
    send(10'd700, 1, 30'd3);
    idle(2);
    check("t2_sum", 32'(cov_sum), 3);

    // clear with idx 11 in flight, idx 12 on the clear cycle
    cov_valid = 1'b1; cov_idx = 10'd11;
    @(posedge clock); #1;
    clear_req = 1'b1; cov_valid = 1'b1; cov_idx = 10'd12;
    @(posedge clock); #1;
    clear_req = 1'b0; cov_valid = 1'b0; cov_idx = 'x;
    check("clr_sum", 32'(cov_sum), 0);
    check("clr_busy", 32'(clear_busy), 1);
    check("clr_new_hit", 32'(new_hit), 0);
    wait_sweep(1'b0, n);
    check("sweep2_len", n, 1024);
    send(10'd5, 1, 30'd1);
    idle(2);
    check("t4_sum", 32'(cov_sum), 1);

    // back-to-back duplicate needs forwarding; later duplicates ignored
    send(10'd42, 1, 30'd2);
    send(10'd42, 0, 30'd0);
    send(10'd42, 0, 30'd0);
    idle(2);
    check("t3_sum", 32'(cov_sum), 2);
    send(10'd5, 0, 30'd0);
    idle(1);
    send(10'd42, 0, 30'd0);
    idle(2);
    check("t3_dup_sum", 32'(cov_sum), 2);

    // saturation on the SUM_W=2 instance
    for (int i = 0; i < 6; i++) begin
      sat_valid = 1'b1; sat_idx = 10'(i * 3 + 1);
      @(posedge clock); #1;
    end
    sat_valid = 1'b0;
    idle(3);
    check("sat_sum", 32'(sat_sum), 3);
    check("sat_hits", sat_hits, 6);

    // reset mid-pipeline: idx 77 is in S1 when reset hits
    send(10'd77, 0, 30'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_sum", 32'(cov_sum), 0);
    check("arst_busy", 32'(clear_busy), 1);
    check("arst_new_hit", 32'(new_hit), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // reset again at sweep_ptr 300
    idle(300);
    #2 reset = 1'b1;
    #1;
    check("arst2_busy", 32'(clear_busy), 1);
    check("arst2_state", 32'(dbg_state), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    wait_sweep(1'b0, n);
    check("sweep3_len", n, 1024);

    for (int i = 0; i < 1024; i++) send(10'(i), 1, 30'(i + 1));
    idle(2);
    check("full_sum", 32'(cov_sum), 1024);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
